// File: rtl/guess_pkg.sv
// ============================================================================
// Module      : guess_pkg
// Description : Shared types and constants for the guess-entry controller.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package guess_pkg;

    localparam int DIGIT_W           = 4;
    localparam int DIGIT_MAX_DEFAULT = 9;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } game_state_t;

endpackage : guess_pkg

`default_nettype wire

// File: rtl/digit_counter.sv
// ============================================================================
// Module      : digit_counter
// Description : One editable modulo-(DIGIT_MAX+1) digit with up/down steps.
//               Hold-to-repeat stepping is present only with AUTO_REPEAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_counter
    import guess_pkg::*;
#(
    parameter int DIGIT_MAX     = DIGIT_MAX_DEFAULT
`ifdef AUTO_REPEAT_EN
   ,parameter int REPEAT_CYCLES = 25000000
`endif
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_clr,
    input  logic   i_en,
    input  logic   i_inc,
    input  logic   i_dec,
`ifdef AUTO_REPEAT_EN
    input  logic   i_inc_lvl,
    input  logic   i_dec_lvl,
`endif
    output digit_t o_digit
);

    localparam digit_t c_max = digit_t'(DIGIT_MAX);

    digit_t r_digit;
    logic   w_up;
    logic   w_dn;

`ifdef AUTO_REPEAT_EN
    localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] r_inc_cnt;
    logic [CNT_W-1:0] r_dec_cnt;
    logic             w_inc_hold;
    logic             w_dec_hold;

    // The edge step restarts the hold count; a repeat fires each time it wraps.
    assign w_inc_hold = i_en && !i_clr && i_inc_lvl && !i_inc;
    assign w_dec_hold = i_en && !i_clr && i_dec_lvl && !i_dec;

    always_ff @(posedge clk) begin
        if (!reset_n || !w_inc_hold || r_inc_cnt == c_last) begin
            r_inc_cnt <= '0;
        end else begin
            r_inc_cnt <= r_inc_cnt + 1'b1;
        end
        if (!reset_n || !w_dec_hold || r_dec_cnt == c_last) begin
            r_dec_cnt <= '0;
        end else begin
            r_dec_cnt <= r_dec_cnt + 1'b1;
        end
    end

    assign w_up = i_inc || (w_inc_hold && r_inc_cnt == c_last);
    assign w_dn = i_dec || (w_dec_hold && r_dec_cnt == c_last);
`else
    assign w_up = i_inc;
    assign w_dn = i_dec;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_digit <= '0;
        end else if (i_en && (w_up ^ w_dn)) begin
            if (w_up) begin
                r_digit <= (r_digit == c_max) ? '0 : r_digit + 1'b1;
            end else begin
                r_digit <= (r_digit == '0) ? c_max : r_digit - 1'b1;
            end
        end
    end

    assign o_digit = r_digit;

endmodule : digit_counter

`default_nettype wire

// File: rtl/guess_entry_ctrl.sv
// ============================================================================
// Module      : guess_entry_ctrl
// Description : Game FSM, button edge detection, digit entry and guess budget.
//               Define AUTO_REPEAT_EN for hold-to-repeat digit stepping.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module guess_entry_ctrl
    import guess_pkg::*;
#(
    parameter int NUM_DIGITS    = 3,
    parameter int DIGIT_MAX     = DIGIT_MAX_DEFAULT,
    parameter int GUESS_W       = 3,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [3:0]                max_digits,
    input  logic [GUESS_W-1:0]        max_guesses,
    input  logic [NUM_DIGITS-1:0]     inc_btn,
    input  logic [NUM_DIGITS-1:0]     dec_btn,
    input  logic                      confirm,
    input  logic                      game_over,
    output logic [NUM_DIGITS*4-1:0]   digits,
    output logic [NUM_DIGITS*4-1:0]   guess_digits,
    output logic                      guess_valid,
    output logic [GUESS_W-1:0]        guesses_left,
    output logic                      out_of_guesses,
    output logic [1:0]                state
);

    localparam logic [3:0] c_num_digits = 4'(NUM_DIGITS);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REPEAT_CYCLES < 1) begin : g_cfg_chk
        $error("guess_entry_ctrl: unsupported NUM_DIGITS or REPEAT_CYCLES");
    end

    logic                    r_start_q;
    logic                    r_confirm_q;
    logic [NUM_DIGITS-1:0]   r_inc_q;
    logic [NUM_DIGITS-1:0]   r_dec_q;
    game_state_t             r_state;
    game_state_t             w_state_nxt;
    logic [3:0]              r_act;
    logic [3:0]              w_act;
    logic [GUESS_W-1:0]      r_budget;
    logic [GUESS_W-1:0]      r_used;
    logic [GUESS_W-1:0]      w_used_inc;
    logic [GUESS_W-1:0]      r_guesses_left;
    logic                    r_oog;
    logic [NUM_DIGITS*4-1:0] r_guess;
    logic                    r_guess_valid;
    logic [NUM_DIGITS*4-1:0] w_digits;
    logic                    w_start_edge;
    logic                    w_confirm_edge;
    logic [NUM_DIGITS-1:0]   w_inc_edge;
    logic [NUM_DIGITS-1:0]   w_dec_edge;
    logic                    w_restart;
    logic                    w_commit;
    logic                    w_final;

    assign w_start_edge   = start & ~r_start_q;
    assign w_confirm_edge = confirm & ~r_confirm_q;
    assign w_inc_edge     = inc_btn & ~r_inc_q;
    assign w_dec_edge     = dec_btn & ~r_dec_q;
    assign w_used_inc     = r_used + GUESS_W'(1);
    assign w_final        = (w_used_inc == r_budget);

    always_comb begin
        w_act = max_digits;
        if (max_digits == 4'd0) begin
            w_act = 4'd1;
        end else if (max_digits > c_num_digits) begin
            w_act = c_num_digits;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                w_restart = w_start_edge;
            end
            ENTRY: begin
                if (w_start_edge) begin
                    w_restart = 1'b1;
                end else begin
                    w_commit = w_confirm_edge;
                    if ((w_confirm_edge && w_final) || game_over) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_restart = w_start_edge;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_restart) begin
            w_state_nxt = (max_guesses == '0) ? DONE : ENTRY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // All-ones so a button held through reset is not seen as a press.
            r_start_q      <= 1'b1;
            r_confirm_q    <= 1'b1;
            r_inc_q        <= '1;
            r_dec_q        <= '1;
            r_state        <= IDLE;
            r_act          <= 4'd0;
            r_budget       <= '0;
            r_used         <= '0;
            r_guesses_left <= '0;
            r_oog          <= 1'b0;
            r_guess        <= '0;
            r_guess_valid  <= 1'b0;
        end else begin
            r_start_q      <= start;
            r_confirm_q    <= confirm;
            r_inc_q        <= inc_btn;
            r_dec_q        <= dec_btn;
            r_state        <= w_state_nxt;
            r_guess_valid  <= w_commit;
            if (w_restart) begin
                r_act          <= w_act;
                r_budget       <= max_guesses;
                r_used         <= '0;
                r_guesses_left <= max_guesses;
                r_oog          <= (max_guesses == '0);
            end else if (w_commit) begin
                r_guess        <= w_digits;
                r_used         <= w_used_inc;
                r_guesses_left <= r_budget - w_used_inc;
                if (w_final) begin
                    r_oog <= 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam logic [3:0] c_idx = 4'(i);

        digit_counter #(
            .DIGIT_MAX     (DIGIT_MAX)
`ifdef AUTO_REPEAT_EN
           ,.REPEAT_CYCLES (REPEAT_CYCLES)
`endif
        ) u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_clr     (w_restart),
            .i_en      ((r_state == ENTRY) && (c_idx < r_act)),
            .i_inc     (w_inc_edge[i]),
            .i_dec     (w_dec_edge[i]),
`ifdef AUTO_REPEAT_EN
            .i_inc_lvl (inc_btn[i]),
            .i_dec_lvl (dec_btn[i]),
`endif
            .o_digit   (w_digits[4*i +: 4])
        );
    end

    assign digits         = w_digits;
    assign guess_digits   = r_guess;
    assign guess_valid    = r_guess_valid;
    assign guesses_left   = r_guesses_left;
    assign out_of_guesses = r_oog;
    assign state          = r_state;

endmodule : guess_entry_ctrl

`default_nettype wire

// File: doc/guess_entry_ctrl.md
Name: guess_entry_ctrl

Overview:
Parametrised successor to the fixed 3-digit guess-entry logic. It holds NUM_DIGITS editable digit counters and turns pushbutton levels into single-step increments or decrements. Each confirm press commits the current digits as a guess and counts down the remaining guesses. It sits between the board pushbutton synchronisers and the guess comparator/display path, and adds a game FSM, proper edge detection, decrement buttons and reset.

Parameters:
NUM_DIGITS, 3, number of digit positions (1..8)
DIGIT_MAX, 9, highest digit value; digits wrap DIGIT_MAX <-> 0
GUESS_W, 3, width of the guess budget and counters
REPEAT_CYCLES, 25000000, hold time in clk cycles before each auto-repeat step (used only with AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
start  in  1  level; rising edge (re)starts a game
max_digits  in  4  active digit count for this game (difficulty)
max_guesses  in  GUESS_W  guess budget for this game
inc_btn  in  NUM_DIGITS  per-digit increment buttons, synchronised levels
dec_btn  in  NUM_DIGITS  per-digit decrement buttons, synchronised levels
confirm  in  1  level; rising edge commits a guess
game_over  in  1  pulse from the comparator (correct guess); ends the game
digits  out  NUM_DIGITS*4  live digit values, digit i at [4i+3:4i]
guess_digits  out  NUM_DIGITS*4  last committed guess
guess_valid  out  1  one-cycle pulse when guess_digits updates
guesses_left  out  GUESS_W  budget minus guesses used
out_of_guesses  out  1  high in DONE when the budget is spent
state  out  2  current FSM state, for display/debug

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; all digits and guess_digits = 0; guess_valid=0; used=0; latched budget=0; guesses_left=0; out_of_guesses=0.
  - Previous-sample registers for start, confirm and buttons reset to all-1s, so a button held through reset produces no edge.
  - Reset mid-game aborts the game with no guess_valid pulse.
- Edge detect: event = current sample high AND previous sample low. One step per press.
- Active digit count: act = clamp(max_digits, 1, NUM_DIGITS). It is latched at the start edge and the live input is ignored mid-game.
- FSM states: IDLE=0, ENTRY=1, DONE=2; 3 is unused and recovers to IDLE.
- IDLE:
  - Buttons and confirm are ignored.
  - On a start edge: clear digits and used, latch act and max_guesses.
  - Next state is ENTRY, or DONE with out_of_guesses=1 if max_guesses=0.
- ENTRY:
  - inc edge on digit i<act: digit+1, wrapping DIGIT_MAX->0.
  - dec edge: digit-1, wrapping 0->DIGIT_MAX.
  - inc and dec edges on the same digit in the same cycle cancel.
  - Digits i>=act are held at 0.
- Confirm edge in ENTRY (sampled at cycle t):
  - At t+1: guess_digits = digits as they were before any cycle-t increment; guess_valid=1 for exactly one cycle; used+1.
  - If used+1 == budget: go to DONE with out_of_guesses=1.
  - A button edge in the same cycle t still updates digits.
- game_over in ENTRY: go to DONE with out_of_guesses=0. If game_over and the final confirm coincide, the guess still commits and out_of_guesses=1.
- DONE: digits are frozen and buttons and confirm are ignored.
- Start edge in ENTRY or DONE restarts exactly as from IDLE.
- guesses_left = budget - used, registered. used never exceeds budget, so there is no underflow.
- Latencies:
  - Button press to digits change: 1 cycle after the edge sample.
  - Start edge to state=ENTRY: 1 cycle.

Optional Feature:
AUTO_REPEAT_EN
- Defined: while an inc_btn or dec_btn stays high in ENTRY, a per-digit hold counter adds an extra step every REPEAT_CYCLES cycles after the initial edge step. The counter clears on release or on leaving ENTRY.
- Undefined: only edges step a digit, REPEAT_CYCLES is unused, and no hold counters are synthesised.

Decomposition:
- Package guess_pkg:
  - DIGIT_W=4
  - typedef digit_t (logic [3:0])
  - enum game_state_t {IDLE, ENTRY, DONE}
  - constant DIGIT_MAX_DEFAULT=9
- Sub-module digit_counter: one per digit via generate. It takes inc/dec edge, enable, clear and the optional repeat logic, and outputs a modulo-(DIGIT_MAX+1) digit.
- The top level holds the FSM, edge detectors, guess register and budget counter.

Test Plan:
- Reset, start with max_digits=3, max_guesses=4, then 11 presses of inc_btn[0] -> digit0=1 (wrap after 9); guesses_left=4; state=ENTRY.
- max_digits=2, press inc_btn[2] and dec_btn[1] -> digit2 stays 0; digit1=9.
- Digits 3,5,7, confirm edge with inc_btn[0] in the same cycle -> next cycle guess_valid=1 for 1 cycle, guess_digits=7,5,3 (digit2,1,0), digit0 then 4, guesses_left=3.
- max_guesses=2, two confirms -> second gives guesses_left=0, out_of_guesses=1, state=DONE; a third confirm gives no pulse.
- confirm held high across reset deassert -> no guess_valid; game_over in ENTRY -> DONE with out_of_guesses=0; start edge -> digits cleared, ENTRY.
- With AUTO_REPEAT_EN and REPEAT_CYCLES=4, hold inc_btn[0] 13 cycles -> digit0=4 (1 edge step + 3 repeat steps).
